// File: rtl/prbs9_checker.sv
// prbs9_checker: self-synchronising x^9+x^5+1 checker; locked_o/err_o/err_cnt_o update one cycle after each valid bit.
// No backpressure (valid_i only qualifies data_i). Defining PRBS9_CHK_BIT_CNT_EN adds the 32-bit bit_cnt_o counter.
module prbs9_checker #(
   parameter int LOCK_CNT    = 16,
   parameter int UNLOCK_ERRS = 8,
   parameter int WIN         = 64,
   parameter int CNT_W       = 16
) (
   input  logic             clk_i,
   input  logic             a_rst_n_i,
   input  logic             data_i,
   input  logic             valid_i,
   input  logic             clear_i,
`ifdef PRBS9_CHK_BIT_CNT_EN
   output logic [31:0]      bit_cnt_o,
`endif
   output logic             locked_o,
   output logic             err_o,
   output logic [CNT_W-1:0] err_cnt_o
);
   localparam int WIN_W  = $clog2(WIN);
   localparam int WERR_W = $clog2(WIN + 1);
   localparam logic [7:0]        LOCK_C   = 8'(LOCK_CNT);
   localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(WIN - 1);
   localparam logic [WERR_W-1:0] UNLOCK_C = WERR_W'(UNLOCK_ERRS);

   typedef enum logic {HUNT, LOCKED} state_e;

   state_e            state_q, state_d;
   logic [8:0]        hist_q, hist_d;
   logic [8:0]        lfsr_q, lfsr_d;
   logic [3:0]        fill_q, fill_d;
   logic [7:0]        match_q, match_d;
   logic [WIN_W-1:0]  win_q, win_d;
   logic [WERR_W-1:0] werr_q, werr_d, werr_inc;
   logic              err_q, err_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              mis;

   // hist_q[0] is the newest bit, so x(n-9) and x(n-5) sit at [8] and [4].
   always_comb begin
      state_d  = state_q;
      hist_d   = hist_q;
      lfsr_d   = lfsr_q;
      fill_d   = fill_q;
      match_d  = match_q;
      win_d    = win_q;
      werr_d   = werr_q;
      werr_inc = werr_q;
      err_d    = 1'b0;
      cnt_d    = cnt_q;
      mis      = 1'b0;
      if (valid_i) begin
         hist_d = {hist_q[7:0], data_i};
         case (state_q)
            HUNT: begin
               if (fill_q != 4'd9) begin
                  fill_d = fill_q + 4'd1;
               end else if (hist_q != 9'd0 && data_i == (hist_q[8] ^ hist_q[4])) begin
                  match_d = match_q + 8'd1;
               end else begin
                  match_d = 8'd0;
               end
               if (match_d == LOCK_C) begin
                  state_d = LOCKED;
                  lfsr_d  = hist_d;
                  match_d = 8'd0;
                  win_d   = '0;
                  werr_d  = '0;
               end
            end
            LOCKED: begin
               // The reference runs on its own predictions; received errors never enter it.
               lfsr_d   = {lfsr_q[7:0], lfsr_q[8] ^ lfsr_q[4]};
               mis      = data_i ^ lfsr_q[8] ^ lfsr_q[4];
               err_d    = mis;
               werr_inc = werr_q + WERR_W'(mis);
               if (werr_inc == UNLOCK_C) begin
                  state_d = HUNT;
                  fill_d  = 4'd0;
                  match_d = 8'd0;
                  win_d   = '0;
                  werr_d  = '0;
               end else if (win_q == WIN_LAST) begin
                  win_d  = '0;
                  werr_d = '0;
               end else begin
                  win_d  = win_q + WIN_W'(1);
                  werr_d = werr_inc;
               end
            end
            default: state_d = HUNT;
         endcase
      end
      if (clear_i) begin
         cnt_d = CNT_W'(mis);
      end else if (mis && cnt_q != '1) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge a_rst_n_i) begin
      if (!a_rst_n_i) begin
         state_q <= HUNT;
         hist_q  <= '0;
         lfsr_q  <= '0;
         fill_q  <= '0;
         match_q <= '0;
         win_q   <= '0;
         werr_q  <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         hist_q  <= hist_d;
         lfsr_q  <= lfsr_d;
         fill_q  <= fill_d;
         match_q <= match_d;
         win_q   <= win_d;
         werr_q  <= werr_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef PRBS9_CHK_BIT_CNT_EN
   logic [31:0] bits_q, bits_d;
   logic        bit_chk;

   assign bit_chk = valid_i && (state_q == LOCKED);

   always_comb begin
      bits_d = bits_q;
      if (clear_i) begin
         bits_d = {31'd0, bit_chk};
      end else if (bit_chk && bits_q != '1) begin
         bits_d = bits_q + 32'd1;
      end
   end

   always_ff @(posedge clk_i or negedge a_rst_n_i) begin
      if (!a_rst_n_i) begin
         bits_q <= '0;
      end else begin
         bits_q <= bits_d;
      end
   end

   assign bit_cnt_o = bits_q;
`endif

   assign locked_o  = (state_q == LOCKED);
   assign err_o     = err_q;
   assign err_cnt_o = cnt_q;
endmodule

// File: doc/prbs9_checker.md
PRBS9_CHECKER -- requirements
Module: prbs9_checker

Interface
REQ-001 SHALL have parameter LOCK_CNT, default 16, number of consecutive correct bits needed to declare lock (range 1..255).
REQ-002 SHALL have parameter UNLOCK_ERRS, default 8, number of errors within one window that drops lock (range 1..WIN).
REQ-003 SHALL have parameter WIN, default 64, error-window length in valid bits (range 2..1024).
REQ-004 SHALL have parameter CNT_W, default 16, width of the error counter.
REQ-005 SHALL have port clk_i  in  1  sole clock; all logic on its rising edge.
REQ-006 SHALL have port a_rst_n_i  in  1  reset; asynchronous assertion, active-low.
REQ-007 SHALL have port data_i  in  1  received PRBS bit.
REQ-008 SHALL have port valid_i  in  1  data_i is sampled on this cycle; no other state advances without it.
REQ-009 SHALL have port clear_i  in  1  synchronous clear of the statistics counters.
REQ-010 SHALL have port locked_o  out  1  checker is synchronised to the stream.
REQ-011 SHALL have port err_o  out  1  one-cycle pulse per bit error detected while locked.
REQ-012 SHALL have port err_cnt_o  out  CNT_W  saturating count of errors.

Function
REQ-013 SHALL check polynomial x^9+x^5+1: expected bit x(n) = x(n-9) XOR x(n-5), seeded at x(0) = first bit after reset.
REQ-014 SHALL implement FSM states HUNT, LOCKED; reset state HUNT.
REQ-015 HUNT: each valid bit shifts into a 9-bit history; comparison starts only once 9 bits are held (fill count 0..9).
REQ-016 HUNT: expected bit comes from received history (self-sync); match with non-zero history increments match count; mismatch or all-zero history clears it to 0.
REQ-017 HUNT -> LOCKED when match count reaches LOCK_CNT; locked_o rises the cycle after the LOCK_CNT-th matching valid bit.
REQ-018 LOCKED: expected bit comes from a local LFSR loaded from history at lock and advanced on each valid bit using predicted bits only; received errors SHALL NOT corrupt it.
REQ-019 LOCKED: mismatch pulses err_o for exactly one cycle, registered, the cycle after the offending valid bit; err_o is 0 in HUNT.
REQ-020 LOCKED: window counter counts valid bits 0..WIN-1 and wraps; per-window error count clears at wrap.
REQ-021 LOCKED -> HUNT when the per-window error count reaches UNLOCK_ERRS; locked_o falls the cycle after; history fill and match count cleared.
REQ-022 err_cnt_o increments per err_o event, saturates at all-ones, never wraps.
REQ-023 clear_i zeroes err_cnt_o next cycle; simultaneous clear_i and error yields err_cnt_o = 1; clear_i does not affect lock state.
REQ-024 valid_i low: no state, counter or window change; err_o low.

Reset
REQ-025 a_rst_n_i low SHALL immediately force: FSM HUNT, locked_o 0, err_o 0, err_cnt_o 0, history/fill/match/window counters 0, at any point mid-operation.
REQ-026 Release SHALL take effect on a clk_i edge; first valid bit after release is history bit x(0).

Configuration
REQ-027 Macro PRBS9_CHK_BIT_CNT_EN defined: SHALL add output bit_cnt_o, 32 bits, saturating count of valid bits checked while LOCKED, reset 0, cleared by clear_i like err_cnt_o.
REQ-028 Macro undefined: bit_cnt_o port and counter SHALL be absent; all other behaviour identical.

Verification
REQ-029 Reset, feed clean PRBS9 (generator seed 1) with valid_i constant 1 -> locked_o rises after 9+16 = 25 valid bits; err_cnt_o stays 0 for 1000 bits.
REQ-030 Locked, invert one bit -> exactly one err_o pulse one cycle later, err_cnt_o = 1, locked_o stays 1, next bits report no error.
REQ-031 Locked, invert 8 bits within one 64-bit window -> locked_o falls after 8th error; clean stream resumes -> relock after 25 valid bits.
REQ-032 Feed all-zero data for 200 valid bits -> locked_o stays 0, err_o never asserts.
REQ-033 Locked, valid_i toggled randomly at 50% duty -> no errors; err_cnt_o preset near max (CNT_W=4, 20 errors) saturates at 15; clear_i with an error same cycle -> 1.
REQ-034 Assert a_rst_n_i between clock edges while locked -> locked_o and err_cnt_o go 0 before next edge; with PRBS9_CHK_BIT_CNT_EN, bit_cnt_o = 0 and then counts only locked valid bits.
